multi_cycle_ctrl: RTL and testbench

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/mips_pkg.sv | 109 ++++++++++
 rtl/multi_cycle_ctrl_if.sv | 37 +++
 rtl/mc_alu_dec.sv | 40 ++++
 rtl/multi_cycle_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// ALU operations, FSM states, mux selects and the instruction classifier.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Shifts compute B << A / B >> A, so lui is an SLL of the immediate by 16.
    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_SUB = 5'd1,
        ALU_AND = 5'd2,
        ALU_OR  = 5'd3,
        ALU_SLT = 5'd4,
        ALU_SLL = 5'd5,
        ALU_SRL = 5'd6
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXE_R  = 4'd2,
        S_EXE_I  = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_ALU = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_JR     = 4'd11,
        S_ERR    = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        CLS_R_ALU   = 3'd0,
        CLS_JR      = 3'd1,
        CLS_I_ALU   = 3'd2,
        CLS_MEM     = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JUMP    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_class_t;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RS     = 2'd3;

    localparam logic [1:0] REG_DST_RT  = 2'd0;
    localparam logic [1:0] REG_DST_RD  = 2'd1;
    localparam logic [1:0] REG_DST_R31 = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_RS    = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;
    localparam logic [1:0] SRCA_C16   = 2'd3;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    function automatic instr_class_t classify(input logic [5:0] op, input logic [5:0] funct);
        instr_class_t cls;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL: cls = CLS_R_ALU;
                    FN_JR:   cls = CLS_JR;
                    default: cls = CLS_ILLEGAL;
                endcase
            end
            OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI: cls = CLS_I_ALU;
            OP_LW, OP_SW:                      cls = CLS_MEM;
            OP_BEQ, OP_BNE:                    cls = CLS_BRANCH;
            OP_J, OP_JAL:                      cls = CLS_JUMP;
            default:                           cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    function automatic logic is_shift(input logic [5:0] funct);
        return (funct == FN_SLL) || (funct == FN_SRL);
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath bundle: decoded instruction fields and status in,
// strobes and mux selects out.
interface multi_cycle_ctrl_if;

    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pc_wr;
    logic       ir_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       iord;
    logic       reg_wr;
    logic       ext_sign;
    logic       illegal;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] mem2reg;
    logic [1:0] alu_srcA;
    logic [1:0] alu_srcB;
    logic [4:0] alu_ctrl;

    modport master (
        input  op, funct, zero, mem_ready,
        output pc_wr, ir_wr, mem_rd, mem_wr, iord, reg_wr, ext_sign, illegal,
        output pc_src, reg_dst, mem2reg, alu_srcA, alu_srcB, alu_ctrl
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pc_wr, ir_wr, mem_rd, mem_wr, iord, reg_wr, ext_sign, illegal,
        input  pc_src, reg_dst, mem2reg, alu_srcA, alu_srcB, alu_ctrl
    );

endinterface

// File: rtl/mc_alu_dec.sv
// ALU operation decoder: picks the ALU opcode from the FSM state and the
// instruction fields; states that only use the ALU as an adder get ADD.
module mc_alu_dec
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output alu_op_t    alu_ctrl
);

    // Combinational ALU opcode selection
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (state)
            S_EXE_R: begin
                case (funct)
                    FN_SUBU: alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    FN_SLL:  alu_ctrl = ALU_SLL;
                    FN_SRL:  alu_ctrl = ALU_SRL;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            S_EXE_I: begin
                case (op)
                    OP_ANDI: alu_ctrl = ALU_AND;
                    OP_ORI:  alu_ctrl = ALU_OR;
                    OP_LUI:  alu_ctrl = ALU_SLL;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            S_BRANCH: alu_ctrl = ALU_SUB;
            default:  alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM with retired-instruction counter.
// Strobes are decoded from the current state and forced low while rst is low.
module multi_cycle_ctrl
    import mips_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    multi_cycle_ctrl_if.master  bus,
    output logic [3:0]          state,
    output logic [31:0]         instr_cnt
);

    state_t       state_r;
    logic [31:0]  instr_cnt_r;
    instr_class_t cls_s;
    alu_op_t      alu_s;

    logic       pc_wr_s;
    logic       ir_wr_s;
    logic       mem_rd_s;
    logic       mem_wr_s;
    logic       iord_s;
    logic       reg_wr_s;
    logic       ext_sign_s;
    logic       illegal_s;
    logic [1:0] pc_src_s;
    logic [1:0] reg_dst_s;
    logic [1:0] mem2reg_s;
    logic [1:0] alu_srca_s;
    logic [1:0] alu_srcb_s;

    assign cls_s = classify(bus.op, bus.funct);

    mc_alu_dec u_alu_dec (
        .state    (state_r),
        .op       (bus.op),
        .funct    (bus.funct),
        .alu_ctrl (alu_s)
    );

    // State register and retire counter; the counter steps on every return to FETCH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_FETCH;
            instr_cnt_r <= 32'd0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        state_r <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (cls_s)
                        CLS_R_ALU:  state_r <= S_EXE_R;
                        CLS_JR:     state_r <= S_JR;
                        CLS_I_ALU:  state_r <= S_EXE_I;
                        CLS_MEM:    state_r <= S_ADDR;
                        CLS_BRANCH: state_r <= S_BRANCH;
                        CLS_JUMP:   state_r <= S_JUMP;
                        default:    state_r <= S_ERR;
                    endcase
                end
                S_EXE_R, S_EXE_I: state_r <= S_WB_ALU;
                S_ADDR:   state_r <= (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD: begin
                    if (bus.mem_ready) begin
                        state_r <= S_WB_MEM;
                    end
                end
                S_MEM_WR: begin
                    if (bus.mem_ready) begin
                        state_r     <= S_FETCH;
                        instr_cnt_r <= instr_cnt_r + 32'd1;
                    end
                end
                S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_JR: begin
                    state_r     <= S_FETCH;
                    instr_cnt_r <= instr_cnt_r + 32'd1;
                end
                S_ERR:   state_r <= S_ERR;
                default: state_r <= S_ERR;
            endcase
        end
    end

    // Per-state strobe and mux-select decode; anything not named stays 0
    always_comb begin
        pc_wr_s    = 1'b0;
        ir_wr_s    = 1'b0;
        mem_rd_s   = 1'b0;
        mem_wr_s   = 1'b0;
        iord_s     = 1'b0;
        reg_wr_s   = 1'b0;
        ext_sign_s = 1'b0;
        illegal_s  = 1'b0;
        pc_src_s   = PC_SRC_ALU;
        reg_dst_s  = REG_DST_RT;
        mem2reg_s  = M2R_ALUOUT;
        alu_srca_s = SRCA_PC;
        alu_srcb_s = SRCB_RT;
        case (state_r)
            S_FETCH: begin
                mem_rd_s   = 1'b1;
                ir_wr_s    = bus.mem_ready;
                pc_wr_s    = bus.mem_ready;
                alu_srcb_s = SRCB_FOUR;
            end
            S_DECODE: begin
                alu_srcb_s = SRCB_IMM_SH2;
                ext_sign_s = 1'b1;
            end
            S_EXE_R: begin
                alu_srca_s = is_shift(bus.funct) ? SRCA_SHAMT : SRCA_RS;
            end
            S_EXE_I: begin
                alu_srca_s = (bus.op == OP_LUI) ? SRCA_C16 : SRCA_RS;
                alu_srcb_s = SRCB_IMM;
                ext_sign_s = (bus.op == OP_ADDIU);
            end
            S_WB_ALU: begin
                reg_wr_s  = 1'b1;
                reg_dst_s = (bus.op == OP_RTYPE) ? REG_DST_RD : REG_DST_RT;
            end
            S_ADDR: begin
                alu_srca_s = SRCA_RS;
                alu_srcb_s = SRCB_IMM;
                ext_sign_s = 1'b1;
            end
            S_MEM_RD: begin
                iord_s   = 1'b1;
                mem_rd_s = 1'b1;
            end
            S_MEM_WR: begin
                iord_s   = 1'b1;
                mem_wr_s = 1'b1;
            end
            S_WB_MEM: begin
                reg_wr_s  = 1'b1;
                mem2reg_s = M2R_MDR;
            end
            S_BRANCH: begin
                alu_srca_s = SRCA_RS;
                pc_src_s   = PC_SRC_ALUOUT;
                pc_wr_s    = (bus.op == OP_BEQ) ? bus.zero : !bus.zero;
            end
            S_JUMP: begin
                pc_wr_s  = 1'b1;
                pc_src_s = PC_SRC_JUMP;
                if (bus.op == OP_JAL) begin
                    reg_wr_s  = 1'b1;
                    reg_dst_s = REG_DST_R31;
                    mem2reg_s = M2R_PC;
                end else begin
                    reg_wr_s  = 1'b0;
                end
            end
            S_JR: begin
                pc_wr_s  = 1'b1;
                pc_src_s = PC_SRC_RS;
            end
            S_ERR: begin
                illegal_s = 1'b1;
            end
            default: begin
                illegal_s = 1'b0;
            end
        endcase
    end

    assign bus.pc_wr    = rst & pc_wr_s;
    assign bus.ir_wr    = rst & ir_wr_s;
    assign bus.mem_rd   = rst & mem_rd_s;
    assign bus.mem_wr   = rst & mem_wr_s;
    assign bus.iord     = rst & iord_s;
    assign bus.reg_wr   = rst & reg_wr_s;
    assign bus.ext_sign = rst & ext_sign_s;
    assign bus.illegal  = rst & illegal_s;
    assign bus.pc_src   = {2{rst}} & pc_src_s;
    assign bus.reg_dst  = {2{rst}} & reg_dst_s;
    assign bus.mem2reg  = {2{rst}} & mem2reg_s;
    assign bus.alu_srcA = {2{rst}} & alu_srca_s;
    assign bus.alu_srcB = {2{rst}} & alu_srcb_s;
    assign bus.alu_ctrl = {5{rst}} & alu_s;

    assign state     = state_r;
    assign instr_cnt = instr_cnt_r;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: per-instruction cycle sequences are
// derived from instruction class and pushed as expectations; a monitor compares.
module tb_multi_cycle_ctrl;
    import mips_pkg::*;

    localparam int K_R = 0, K_SHIFT = 1, K_JR = 2, K_IALU = 3, K_LUI = 4, K_LW = 5,
                   K_SW = 6, K_BEQ = 7, K_BNE = 8, K_J = 9, K_JAL = 10, K_ILL = 11;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_wr, ir_wr, mem_rd, mem_wr, iord, reg_wr, ext_sign, illegal;
        logic [1:0] pc_src, reg_dst, mem2reg, srca, srcb;
        logic [4:0] alu;
    } ctrl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        int         kind;
        logic [4:0] alu;
    } instr_t;

    typedef struct {
        ctrl_t       c;
        logic [31:0] cnt;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  state;
    logic [31:0] instr_cnt;

    multi_cycle_ctrl_if bus ();

    multi_cycle_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state     (state),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc_n   = 0;
    logic [31:0] cnt_m   = 32'd0;
    instr_t      tbl[18];
    exp_t        mon_e;
    ctrl_t       act;

    function automatic logic rbit();
        return ($urandom_range(1, 0) == 1);
    endfunction

    function automatic instr_t ill(input logic [5:0] op, input logic [5:0] funct);
        instr_t t;
        t.op = op; t.funct = funct; t.kind = K_ILL; t.alu = ALU_ADD;
        return t;
    endfunction

    // Expected controller outputs for one cycle spent in phase ph of instruction in
    function automatic ctrl_t model(input logic r, input state_t ph, input instr_t in,
                                    input logic z, input logic rdy);
        ctrl_t c;
        c = '0;
        if (r) begin
            c.st  = ph;
            c.alu = ALU_ADD;
            case (ph)
                S_FETCH:  begin c.mem_rd = 1'b1; c.srcb = 2'd1; c.ir_wr = rdy; c.pc_wr = rdy; end
                S_DECODE: begin c.srcb = 2'd3; c.ext_sign = 1'b1; end
                S_EXE_R:  begin c.srca = (in.kind == K_SHIFT) ? 2'd2 : 2'd1; c.alu = in.alu; end
                S_EXE_I:  begin
                    c.srca = (in.kind == K_LUI) ? 2'd3 : 2'd1;
                    c.srcb = 2'd2;
                    c.ext_sign = (in.op == 6'h09);
                    c.alu = in.alu;
                end
                S_WB_ALU: begin c.reg_wr = 1'b1; c.reg_dst = (in.kind == K_R || in.kind == K_SHIFT) ? 2'd1 : 2'd0; end
                S_ADDR:   begin c.srca = 2'd1; c.srcb = 2'd2; c.ext_sign = 1'b1; end
                S_MEM_RD: begin c.iord = 1'b1; c.mem_rd = 1'b1; end
                S_MEM_WR: begin c.iord = 1'b1; c.mem_wr = 1'b1; end
                S_WB_MEM: begin c.reg_wr = 1'b1; c.mem2reg = 2'd1; end
                S_BRANCH: begin
                    c.alu = ALU_SUB; c.srca = 2'd1; c.pc_src = 2'd1;
                    c.pc_wr = (in.kind == K_BEQ) ? z : !z;
                end
                S_JUMP: begin
                    c.pc_wr = 1'b1; c.pc_src = 2'd2;
                    if (in.kind == K_JAL) begin c.reg_wr = 1'b1; c.reg_dst = 2'd2; c.mem2reg = 2'd2; end
                end
                S_JR:    begin c.pc_wr = 1'b1; c.pc_src = 2'd3; end
                S_ERR:   c.illegal = 1'b1;
                default: c.illegal = 1'b0;
            endcase
        end
        return c;
    endfunction

    task automatic drive(input logic r, input state_t ph, input instr_t in, input logic z, input logic rdy);
        exp_t e;
        rst = r;
        bus.op = in.op;
        bus.funct = in.funct;
        bus.zero = z;
        bus.mem_ready = rdy;
        e.c   = model(r, ph, in, z, rdy);
        e.cnt = r ? cnt_m : 32'd0;
        e.cyc = cyc_n;
        exp_q.push_back(e);
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        cnt_m = 32'd0;
        for (int i = 0; i < n; i++) drive(1'b0, S_FETCH, tbl[$urandom_range(17, 0)], rbit(), rbit());
    endtask

    // Builds the cycle list of one instruction from its class, then plays it
    task automatic run_instr(input instr_t in, input int wf, input int wm, input logic zb, input int abort_at);
        state_t ph_q[$];
        logic   rdy_q[$];
        state_t body[$];
        logic   aborted;
        for (int i = 0; i < wf; i++) begin ph_q.push_back(S_FETCH); rdy_q.push_back(1'b0); end
        ph_q.push_back(S_FETCH); rdy_q.push_back(1'b1);
        body.push_back(S_DECODE);
        case (in.kind)
            K_R, K_SHIFT:  begin body.push_back(S_EXE_R); body.push_back(S_WB_ALU); end
            K_JR:          body.push_back(S_JR);
            K_IALU, K_LUI: begin body.push_back(S_EXE_I); body.push_back(S_WB_ALU); end
            K_LW:          begin body.push_back(S_ADDR); body.push_back(S_MEM_RD); body.push_back(S_WB_MEM); end
            K_SW:          begin body.push_back(S_ADDR); body.push_back(S_MEM_WR); end
            K_BEQ, K_BNE:  body.push_back(S_BRANCH);
            K_J, K_JAL:    body.push_back(S_JUMP);
            default:       for (int i = 0; i < 10; i++) body.push_back(S_ERR);
        endcase
        foreach (body[i]) begin
            if (body[i] == S_MEM_RD || body[i] == S_MEM_WR) begin
                for (int w = 0; w < wm; w++) begin ph_q.push_back(body[i]); rdy_q.push_back(1'b0); end
                ph_q.push_back(body[i]); rdy_q.push_back(1'b1);
            end else begin
                ph_q.push_back(body[i]); rdy_q.push_back(rbit());
            end
        end
        aborted = 1'b0;
        for (int i = 0; i < ph_q.size(); i++) begin
            if (!aborted) begin
                if (i == abort_at) begin
                    aborted = 1'b1;
                    cnt_m = 32'd0;
                    drive(1'b0, S_FETCH, in, rbit(), rbit());
                end else begin
                    drive(1'b1, ph_q[i], in, (ph_q[i] == S_BRANCH) ? zb : rbit(), rdy_q[i]);
                end
            end
        end
        if (!aborted && in.kind != K_ILL) cnt_m = cnt_m + 32'd1;
    endtask

    // Monitor: pops one expectation per cycle and compares at the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                act.st = state;          act.pc_wr = bus.pc_wr;   act.ir_wr = bus.ir_wr;
                act.mem_rd = bus.mem_rd; act.mem_wr = bus.mem_wr; act.iord = bus.iord;
                act.reg_wr = bus.reg_wr; act.ext_sign = bus.ext_sign; act.illegal = bus.illegal;
                act.pc_src = bus.pc_src; act.reg_dst = bus.reg_dst; act.mem2reg = bus.mem2reg;
                act.srca = bus.alu_srcA; act.srcb = bus.alu_srcB; act.alu = bus.alu_ctrl;
                n_tests++;
                if (act !== mon_e.c) begin
                    n_fail++;
                    $display("FAIL ctrl cycle %0d: got %h expected %h", mon_e.cyc, act, mon_e.c);
                end
                n_tests++;
                if (instr_cnt !== mon_e.cnt) begin
                    n_fail++;
                    $display("FAIL instr_cnt cycle %0d: got %h expected %h", mon_e.cyc, instr_cnt, mon_e.cnt);
                end
                n_tests++;
                if (bus.mem_rd && bus.mem_wr) begin
                    n_fail++;
                    $display("FAIL mem_excl cycle %0d: got mem_rd=1 mem_wr=1 expected not both", mon_e.cyc);
                end
            end
        end
    end

    initial begin
        tbl[0]  = '{6'h00, 6'h21, K_R,     ALU_ADD};
        tbl[1]  = '{6'h00, 6'h23, K_R,     ALU_SUB};
        tbl[2]  = '{6'h00, 6'h24, K_R,     ALU_AND};
        tbl[3]  = '{6'h00, 6'h25, K_R,     ALU_OR};
        tbl[4]  = '{6'h00, 6'h2A, K_R,     ALU_SLT};
        tbl[5]  = '{6'h00, 6'h00, K_SHIFT, ALU_SLL};
        tbl[6]  = '{6'h00, 6'h02, K_SHIFT, ALU_SRL};
        tbl[7]  = '{6'h00, 6'h08, K_JR,    ALU_ADD};
        tbl[8]  = '{6'h09, 6'h15, K_IALU,  ALU_ADD};
        tbl[9]  = '{6'h0C, 6'h3F, K_IALU,  ALU_AND};
        tbl[10] = '{6'h0D, 6'h01, K_IALU,  ALU_OR};
        tbl[11] = '{6'h0F, 6'h2A, K_LUI,   ALU_SLL};
        tbl[12] = '{6'h23, 6'h04, K_LW,    ALU_ADD};
        tbl[13] = '{6'h2B, 6'h08, K_SW,    ALU_ADD};
        tbl[14] = '{6'h04, 6'h10, K_BEQ,   ALU_SUB};
        tbl[15] = '{6'h05, 6'h11, K_BNE,   ALU_SUB};
        tbl[16] = '{6'h02, 6'h33, K_J,     ALU_ADD};
        tbl[17] = '{6'h03, 6'h00, K_JAL,   ALU_ADD};
        bus.op = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;

        @(posedge clk);
        #1;
        do_reset(3);
        run_instr(tbl[0], 0, 0, 1'b0, -1);
        run_instr(tbl[12], 0, 2, 1'b0, -1);
        run_instr(tbl[14], 0, 0, 1'b1, -1);
        run_instr(tbl[14], 0, 0, 1'b0, -1);
        run_instr(tbl[15], 1, 0, 1'b0, -1);
        run_instr(tbl[17], 0, 0, 1'b0, -1);

        force dut.instr_cnt_r = 32'hFFFF_FFFF;
        cnt_m = 32'hFFFF_FFFF;
        #1;
        release dut.instr_cnt_r;
        run_instr(tbl[16], 0, 0, 1'b0, -1);
        run_instr(tbl[0], 0, 0, 1'b0, -1);

        for (int i = 0; i < 150; i++) begin
            run_instr(tbl[$urandom_range(17, 0)], int'($urandom_range(2, 0)),
                      int'($urandom_range(3, 0)), rbit(), -1);
        end

        run_instr(ill(6'h3F, 6'h00), 0, 0, 1'b0, -1);
        do_reset(2);
        run_instr(ill(6'h00, 6'h20), 1, 0, 1'b0, -1);
        do_reset(1);
        run_instr(ill(6'h08, 6'h21), 0, 0, 1'b0, -1);
        do_reset(1);

        run_instr(tbl[13], 0, 5, 1'b0, 4);
        do_reset(1);
        run_instr(tbl[1], 0, 0, 1'b0, -1);
        run_instr(tbl[13], 2, 1, 1'b0, -1);

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
